// File: rtl/pz_da_pkg.sv
// Shared definitions for the DAC serial link: frame geometry, command/address
// codes, responder state encoding and the channel-update decode.
package pz_da_pkg;

    localparam int DEF_FRAME_BITS = 24;
    localparam int DEF_DATA_W     = 16;

    localparam logic [2:0] CMD_WR_UPD = 3'b011;

    localparam logic [2:0] ADDR_A   = 3'b000;
    localparam logic [2:0] ADDR_B   = 3'b001;
    localparam logic [2:0] ADDR_ALL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } pz_da_state_e;

    // Returns {load_b, load_a} for a committed word.
    function automatic logic [1:0] ch_upd_mask(input logic [2:0] cmd, input logic [2:0] addr);
        logic [1:0] mask;
        mask = 2'b00;
        if (cmd == CMD_WR_UPD) begin
            case (addr)
                ADDR_A:   mask = 2'b01;
                ADDR_B:   mask = 2'b10;
                ADDR_ALL: mask = 2'b11;
                default:  mask = 2'b00;
            endcase
        end else begin
            mask = 2'b00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pz_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, followed by a history
// flop that yields single-cycle rise/fall strikes in the clk domain.
module pz_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_r;
    logic       hist_r;

    // Synchronizer chain and history flop, reset to the line's idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {RST_VAL, RST_VAL};
            hist_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[0], async_in};
            hist_r <= sync_r[1];
        end
    end

    assign level = sync_r[1];
    assign rise  = sync_r[1] & ~hist_r;
    assign fall  = ~sync_r[1] & hist_r;

endmodule

// File: rtl/pz_da_spi_rx.sv
// SPI responder for the 24-bit DAC link: deframes nsync/sclk/mosi into
// command/address/data words, maintains channel A/B codes, daisy-chains MISO.
module pz_da_spi_rx
    import pz_da_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_nsync,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              word_valid,
    output logic [2:0]        word_cmd,
    output logic [2:0]        word_addr,
    output logic [DATA_W-1:0] word_data,
    output logic [DATA_W-1:0] ch_a,
    output logic [DATA_W-1:0] ch_b,
    output logic              frame_err
);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic nsync_lvl_s, nsync_rise_s, nsync_fall_s;
    logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    pz_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_in(spi_sclk),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    pz_sync_edge #(.RST_VAL(1'b1)) u_sync_nsync (
        .clk(clk), .rst(rst), .async_in(spi_nsync),
        .level(nsync_lvl_s), .rise(nsync_rise_s), .fall(nsync_fall_s)
    );

    pz_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(spi_mosi),
        .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_s = ^{sclk_lvl_s, nsync_lvl_s, mosi_rise_s, mosi_fall_s};

    pz_da_state_e              state_r, state_nx_s;
    logic [FRAME_BITS-1:0]     shift_r;
    logic [FRAME_BITS-1:0]     frame_nx_s;
    logic [4:0]                cnt_r;
    logic                      ovr_r;
    logic                      last_fall_s;
    logic                      commit_s, err_s, shift_s, clr_cnt_s, ovr_set_s, miso_en_s;
    logic [1:0]                upd_mask_s;

    assign frame_nx_s  = {shift_r[FRAME_BITS-2:0], mosi_lvl_s};
    assign last_fall_s = sclk_fall_s & (cnt_r == 5'(FRAME_BITS - 1));
    assign upd_mask_s  = ch_upd_mask(frame_nx_s[21:19], frame_nx_s[18:16]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; a last fall coinciding with nsync rise commits and returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (nsync_fall_s) state_nx_s = ST_SHIFT;
                else              state_nx_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_fall_s)       state_nx_s = nsync_rise_s ? ST_IDLE : ST_FULL;
                else if (nsync_rise_s) state_nx_s = ST_IDLE;
                else                   state_nx_s = ST_SHIFT;
            end
            ST_FULL: begin
                if (nsync_rise_s) state_nx_s = ST_IDLE;
                else              state_nx_s = ST_FULL;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        commit_s  = 1'b0;
        err_s     = 1'b0;
        shift_s   = 1'b0;
        clr_cnt_s = 1'b0;
        ovr_set_s = 1'b0;
        miso_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clr_cnt_s = nsync_fall_s;
            end
            ST_SHIFT: begin
                shift_s   = sclk_fall_s;
                commit_s  = last_fall_s;
                err_s     = nsync_rise_s & ~last_fall_s;
                miso_en_s = 1'b1;
            end
            ST_FULL: begin
                ovr_set_s = sclk_fall_s;
                err_s     = nsync_rise_s & (ovr_r | sclk_fall_s);
                miso_en_s = 1'b1;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Bit counter (saturating at FRAME_BITS), overrun flag and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 5'd0;
            ovr_r   <= 1'b0;
            shift_r <= '0;
        end else begin
            if (clr_cnt_s) begin
                cnt_r <= 5'd0;
                ovr_r <= 1'b0;
            end else begin
                if (shift_s && (cnt_r != 5'(FRAME_BITS))) cnt_r <= cnt_r + 5'd1;
                if (ovr_set_s) ovr_r <= 1'b1;
            end
            if (shift_s) shift_r <= frame_nx_s;
        end
    end

    // Committed word, channel codes and one-cycle strikes.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            word_cmd   <= 3'd0;
            word_addr  <= 3'd0;
            word_data  <= '0;
            ch_a       <= '0;
            ch_b       <= '0;
        end else begin
            word_valid <= commit_s;
            frame_err  <= err_s;
            if (commit_s) begin
                word_cmd  <= frame_nx_s[21:19];
                word_addr <= frame_nx_s[18:16];
                word_data <= frame_nx_s[DATA_W-1:0];
                if (upd_mask_s[0]) ch_a <= frame_nx_s[DATA_W-1:0];
                if (upd_mask_s[1]) ch_b <= frame_nx_s[DATA_W-1:0];
            end
        end
    end

    // Daisy-chain output: previous register MSB on each SCLK rise, parked low in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_miso <= 1'b0;
        end else if (!miso_en_s) begin
            spi_miso <= 1'b0;
        end else if (sclk_rise_s) begin
            spi_miso <= shift_r[FRAME_BITS-1];
        end else begin
            spi_miso <= spi_miso;
        end
    end

endmodule

// File: tb/tb_pz_da_spi_rx.sv
// Bench for pz_da_spi_rx: directed and random SPI frames at sclk = clk/8,
// checked against a frame-level reference model.
module tb_pz_da_spi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_nsync = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        word_valid;
    logic [2:0]  word_cmd;
    logic [2:0]  word_addr;
    logic [15:0] word_data;
    logic [15:0] ch_a;
    logic [15:0] ch_b;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [23:0] m_sr = 24'd0;
    logic [2:0]  m_cmd = 3'd0;
    logic [2:0]  m_addr = 3'd0;
    logic [15:0] m_data = 16'd0;
    logic [15:0] m_cha = 16'd0;
    logic [15:0] m_chb = 16'd0;

    pz_da_spi_rx dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_nsync(spi_nsync), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .word_valid(word_valid),
        .word_cmd(word_cmd), .word_addr(word_addr), .word_data(word_data),
        .ch_a(ch_a), .ch_b(ch_b), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) valid_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".cmd"},  32'(word_cmd),  32'(m_cmd));
        chk({tag, ".addr"}, 32'(word_addr), 32'(m_addr));
        chk({tag, ".data"}, 32'(word_data), 32'(m_data));
        chk({tag, ".ch_a"}, 32'(ch_a),      32'(m_cha));
        chk({tag, ".ch_b"}, 32'(ch_b),      32'(m_chb));
    endtask

    // Drives one frame of n clocks (first 24 bits from f, MSB first), then
    // updates the model and checks strikes, fields, channels and MISO.
    task automatic run_frame(input string tag, input logic [23:0] f, input int n);
        int          v0, e0, m, bitv;
        logic [23:0] cap, exp_cap, prev_sr;
        v0 = valid_cnt;
        e0 = err_cnt;
        prev_sr = m_sr;
        cap = 24'd0;
        spi_nsync = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            bitv = (i < 24) ? int'((f >> (23 - i)) & 24'd1) : int'($urandom_range(0, 1));
            spi_mosi = bitv[0];
            spi_sclk = 1'b1;
            wait_clk(4);
            if (i < 24) cap = (cap << 1) | 24'(spi_miso);
            spi_sclk = 1'b0;
            wait_clk(4);
            if (i < 24) m_sr = (m_sr << 1) | 24'(bitv);
        end
        spi_nsync = 1'b1;
        wait_clk(10);

        if (n >= 24) begin
            m_cmd  = 3'((f >> 19) & 24'h7);
            m_addr = 3'((f >> 16) & 24'h7);
            m_data = 16'(f & 24'hFFFF);
            if (m_cmd == 3'd3) begin
                if (m_addr == 3'd0 || m_addr == 3'd7) m_cha = m_data;
                if (m_addr == 3'd1 || m_addr == 3'd7) m_chb = m_data;
            end
        end
        chk({tag, ".valid_strikes"}, 32'(valid_cnt - v0), (n >= 24) ? 32'd1 : 32'd0);
        chk({tag, ".err_strikes"},   32'(err_cnt - e0),   (n != 24) ? 32'd1 : 32'd0);
        chk_outputs(tag);
        m = (n < 24) ? n : 24;
        if (m > 0) begin
            exp_cap = prev_sr >> (24 - m);
            chk({tag, ".miso"}, 32'(cap), 32'(exp_cap));
        end
        chk({tag, ".miso_idle"}, 32'(spi_miso), 32'd0);
    endtask

    initial begin
        int          v0, e0, sel, n;
        logic [23:0] f;

        rst = 1'b1;
        wait_clk(4);
        chk("reset.valid", 32'(word_valid), 32'd0);
        chk("reset.err",   32'(frame_err),  32'd0);
        chk("reset.miso",  32'(spi_miso),   32'd0);
        chk_outputs("reset");
        rst = 1'b0;
        wait_clk(6);

        run_frame("wr_a",      24'h188000, 24);
        run_frame("wr_all",    24'h1F1234, 24);
        run_frame("cmd0",      24'h00ABCD, 24);
        run_frame("short10",   24'h1F5555, 10);
        run_frame("long26",    24'h19BEEF, 26);
        run_frame("b2b_first", 24'h180001, 24);
        run_frame("b2b_second", 24'h190002, 24);

        for (int k = 0; k < 10; k++) begin
            f = 24'($urandom);
            if ($urandom_range(0, 1) == 1) f = (f & ~(24'h7 << 19)) | (24'h3 << 19);
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      n = int'($urandom_range(1, 23));
            else if (sel <= 3) n = 24;
            else               n = int'($urandom_range(25, 27));
            run_frame($sformatf("rand%0d", k), f, n);
        end

        // Reset in the middle of a frame
        v0 = valid_cnt;
        e0 = err_cnt;
        spi_nsync = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
            wait_clk(4);
        end
        rst = 1'b1;
        wait_clk(3);
        m_sr = 24'd0; m_cmd = 3'd0; m_addr = 3'd0; m_data = 16'd0; m_cha = 16'd0; m_chb = 16'd0;
        chk("midrst.valid", 32'(word_valid), 32'd0);
        chk("midrst.err",   32'(frame_err),  32'd0);
        chk("midrst.miso",  32'(spi_miso),   32'd0);
        chk_outputs("midrst");
        spi_nsync = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(12);
        chk("midrst.valid_strikes", 32'(valid_cnt - v0), 32'd0);
        chk("midrst.err_strikes",   32'(err_cnt - e0),   32'd0);
        chk_outputs("post_rst");

        run_frame("after_rst", 24'h1F0F0F, 24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
